// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 5x5 sliding-window CNN front end.
// Streams one IX x IY frame from image RAM into the line buffer in raster
// order, tags every window the line buffer emits with its (x,y) output
// coordinate, and reports frame completion or a drain timeout.
//
// Flow control: a RAM read is issued (o_mem_rd_en) only in cycles following
// a clock edge at which i_ds_ready was high, so reads stop the cycle after
// i_ds_ready falls. Data returns one cycle after the read and is forwarded to
// the line buffer as o_lb_valid/o_lb_pixel with no stall capability; the
// downstream must absorb the windows already in the line-buffer pipeline.
// Windows (i_lb_window_valid) are always accepted and never back-pressured.
module conv_frame_ctrl #(
  parameter int I_F_BW  = 8,
  parameter int IX      = 28,
  parameter int IY      = 28,
  parameter int KX      = 5,
  parameter int KY      = 5,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_ds_ready,
  output logic                       o_mem_rd_en,
  output logic [$clog2(IX*IY)-1:0]   o_mem_addr,
  input  logic [I_F_BW-1:0]          i_mem_rdata,
  output logic                       o_lb_clear,
  output logic                       o_lb_valid,
  output logic [I_F_BW-1:0]          o_lb_pixel,
  input  logic                       i_lb_window_valid,
  output logic [$clog2(IX)-1:0]      o_win_x,
  output logic [$clog2(IY)-1:0]      o_win_y,
  output logic                       o_win_last,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [2:0]                 o_state
);

  localparam int NWX  = IX - KX + 1;
  localparam int NWY  = IY - KY + 1;
  localparam int NWIN = NWX * NWY;
  localparam int NPIX = IX * IY;
  localparam int AW   = $clog2(IX*IY);
  localparam int XW   = $clog2(IX);
  localparam int YW   = $clog2(IY);
  localparam int CW   = $clog2(NWIN + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] PIX_LAST  = AW'(NPIX - 1);
  localparam logic [CW-1:0] WIN_TOTAL = CW'(NWIN);
  localparam logic [CW-1:0] WIN_LAST  = CW'(NWIN - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(NWX - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   pix_cnt;
  logic [CW-1:0]   win_cnt;
  logic [XW-1:0]   win_x;
  logic [YW-1:0]   win_y;
  logic [TW-1:0]   idle_cnt;
  logic            err;

  logic            tracking;
  logic            win_ok;
  logic            win_is_last;

  // Windows only count while a frame is live and before the full set is seen.
  assign tracking    = (state == S_CLEAR) || (state == S_FETCH) || (state == S_DRAIN);
  assign win_ok      = tracking && i_lb_window_valid && (win_cnt < WIN_TOTAL);
  assign win_is_last = win_ok && (win_cnt == WIN_LAST);

  assign o_win_x    = win_x;
  assign o_win_y    = win_y;
  assign o_win_last = win_is_last;
  assign o_lb_pixel = i_mem_rdata;
  assign o_state    = state;

  // Frame FSM, read address generation, window tagging and drain timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      win_cnt     <= '0;
      win_x       <= '0;
      win_y       <= '0;
      idle_cnt    <= '0;
      err         <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_mem_addr  <= '0;
      o_lb_clear  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_lb_clear  <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;

      // Coordinates hold on the final window so they stay at (NWX-1,NWY-1).
      if (win_ok) begin
        win_cnt <= win_cnt + CW'(1);
        if (!win_is_last) begin
          if (win_x == X_LAST) begin
            win_x <= '0;
            win_y <= win_y + YW'(1);
          end else begin
            win_x <= win_x + XW'(1);
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_CLEAR;
            o_lb_clear <= 1'b1;
            o_busy     <= 1'b1;
            pix_cnt    <= '0;
            win_cnt    <= '0;
            win_x      <= '0;
            win_y      <= '0;
            idle_cnt   <= '0;
            err        <= 1'b0;
            o_mem_addr <= '0;
          end
        end
        S_CLEAR: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_ds_ready) begin
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= pix_cnt;
            pix_cnt     <= pix_cnt + AW'(1);
            if (pix_cnt == PIX_LAST) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (win_is_last || (win_cnt == WIN_TOTAL)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_err  <= err;
          end else if (win_ok) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= idle_cnt + TW'(1);
            err      <= 1'b1;
            state    <= S_DONE;
            o_done   <= 1'b1;
            o_err    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      // Abort cancels the frame outright; it cannot collide with a start
      // because start is only honoured in IDLE.
      if (i_abort && (state != S_IDLE)) begin
        state       <= S_IDLE;
        o_busy      <= 1'b0;
        o_mem_rd_en <= 1'b0;
        o_mem_addr  <= '0;
        o_lb_clear  <= 1'b0;
        o_done      <= 1'b0;
        o_err       <= 1'b0;
        pix_cnt     <= '0;
        win_cnt     <= '0;
        win_x       <= '0;
        win_y       <= '0;
        idle_cnt    <= '0;
        err         <= 1'b0;
      end
    end
  end

  // Pixel valid trails the read strobe by the RAM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_lb_valid <= 1'b0;
    end else begin
      o_lb_valid <= o_mem_rd_en;
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a behavioural image RAM and
// 28x28 / 5x5 line-buffer model.
module tb_conv_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        i_start;
  logic        i_abort;
  logic        i_ds_ready;
  logic        o_mem_rd_en;
  logic [9:0]  o_mem_addr;
  logic [7:0]  i_mem_rdata;
  logic        o_lb_clear;
  logic        o_lb_valid;
  logic [7:0]  o_lb_pixel;
  logic        i_lb_window_valid;
  logic [4:0]  o_win_x;
  logic [4:0]  o_win_y;
  logic        o_win_last;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [2:0]  o_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_frame_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_ds_ready        (i_ds_ready),
    .o_mem_rd_en       (o_mem_rd_en),
    .o_mem_addr        (o_mem_addr),
    .i_mem_rdata       (i_mem_rdata),
    .o_lb_clear        (o_lb_clear),
    .o_lb_valid        (o_lb_valid),
    .o_lb_pixel        (o_lb_pixel),
    .i_lb_window_valid (i_lb_window_valid),
    .o_win_x           (o_win_x),
    .o_win_y           (o_win_y),
    .o_win_last        (o_win_last),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_state           (o_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // Monitor statistics, cleared through mon_clr.
  bit mon_clr = 1'b0;
  int cyc = 0;
  int rd_cnt, addr_err, bp_err, exp_addr;
  int lbv_cnt, pix_err, exp_pix;
  int mon_win, win_err, last_cnt, last_win_cyc;
  int clr_cnt, done_cnt, done_cyc;
  bit ds_prev = 1'b1;

  // Environment model state.
  bit          rd_pend = 1'b0;
  logic [9:0]  addr_pend = '0;
  bit          win_pend = 1'b0;
  bit          force_win = 1'b0;
  int          win_limit = 576;
  int          lb_pix = 0;
  int          lb_emit = 0;

  // Expected window coordinates in raster order, refilled per frame.
  logic [9:0] exp_q[$];

  function automatic logic [7:0] pix_fn(input logic [9:0] a);
    logic [15:0] t;
    t = {6'd0, a} * 16'd7 + 16'd3;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor plus RAM / line-buffer observation on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      rd_cnt = 0; addr_err = 0; bp_err = 0; exp_addr = 0;
      lbv_cnt = 0; pix_err = 0; exp_pix = 0;
      mon_win = 0; win_err = 0; last_cnt = 0; last_win_cyc = 0;
      clr_cnt = 0; done_cnt = 0; done_cyc = 0;
      exp_q.delete();
      for (int y = 0; y < 24; y++)
        for (int x = 0; x < 24; x++)
          exp_q.push_back({y[4:0], x[4:0]});
    end else begin
      if (o_mem_rd_en) begin
        rd_cnt++;
        if (o_mem_addr !== 10'(exp_addr)) addr_err++;
        if (!ds_prev) bp_err++;
        exp_addr++;
      end
      if (o_lb_valid) begin
        lbv_cnt++;
        if (o_lb_pixel !== pix_fn(10'(exp_pix))) pix_err++;
        exp_pix++;
      end
      if (i_lb_window_valid) begin
        if (exp_q.size() > 0) begin
          if ({o_win_y, o_win_x} !== exp_q[0]) win_err++;
          void'(exp_q.pop_front());
        end else begin
          win_err++;
        end
        if (o_win_last) begin
          last_cnt++;
          if (mon_win != 575) win_err++;
        end
        mon_win++;
        last_win_cyc = cyc;
      end
      if (o_lb_clear) clr_cnt++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    ds_prev = i_ds_ready;
    // RAM read capture (data returns one cycle later).
    rd_pend   = o_mem_rd_en;
    addr_pend = o_mem_addr;
    // Line buffer: window once a pixel at row>=4, col>=4 has been pushed.
    win_pend = 1'b0;
    if (o_lb_clear) begin
      lb_pix  = 0;
      lb_emit = 0;
    end else if (o_lb_valid) begin
      if ((lb_pix / 28) >= 4 && (lb_pix % 28) >= 4) begin
        if (lb_emit < win_limit) win_pend = 1'b1;
        lb_emit++;
      end
      lb_pix++;
    end
  end

  // Drive RAM data and window strobe just after the active edge.
  always @(posedge clk) begin
    #1;
    i_mem_rdata       = rd_pend ? pix_fn(addr_pend) : 8'h00;
    i_lb_window_valid = win_pend | force_win;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_monitor;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic start_frame;
    clear_monitor();
    i_start = 1'b1;
    tick();
    chk("start_lb_clear", o_lb_clear, 1);
    chk("start_state_clear", o_state, 3'd1);
    chk("start_busy", o_busy, 1);
    i_start = 1'b0;
    tick();
    chk("clear_one_cycle", o_lb_clear, 0);
  endtask

  task automatic run_frame(input bit toggle, output bit seen_done, output bit seen_err);
    seen_done = 1'b0;
    seen_err  = 1'b0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      i_ds_ready = toggle ? (((c / 4) % 2) == 0) : 1'b1;
      tick();
      if (o_done) begin
        seen_done = 1'b1;
        seen_err  = o_err;
      end
    end
    i_ds_ready = 1'b1;
    tick();
  endtask

  task automatic full_frame_checks(input string tag, input bit seen_done, input bit seen_err);
    chk({tag, "_done"}, seen_done, 1);
    chk({tag, "_err"}, seen_err, 0);
    chk({tag, "_reads"}, rd_cnt, 784);
    chk({tag, "_addr_seq"}, addr_err, 0);
    chk({tag, "_read_while_not_ready"}, bp_err, 0);
    chk({tag, "_lb_valid_cnt"}, lbv_cnt, 784);
    chk({tag, "_pixel_data"}, pix_err, 0);
    chk({tag, "_windows"}, mon_win, 576);
    chk({tag, "_win_coords"}, win_err, 0);
    chk({tag, "_win_last_cnt"}, last_cnt, 1);
    chk({tag, "_clear_pulses"}, clr_cnt, 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_idle_after"}, o_state, 3'd0);
    chk({tag, "_busy_after"}, o_busy, 0);
    chk({tag, "_err_after"}, o_err, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, o_state, 3'd0);
    chk({tag, "_rd_en"}, o_mem_rd_en, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_lb_clear"}, o_lb_clear, 0);
    chk({tag, "_lb_valid"}, o_lb_valid, 0);
    chk({tag, "_win_x"}, o_win_x, 0);
    chk({tag, "_win_y"}, o_win_y, 0);
    chk({tag, "_win_last"}, o_win_last, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit seen_done, seen_err;
    int waited;

    reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ds_ready = 1'b1;
    i_mem_rdata = 8'h00; i_lb_window_valid = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1: full frame, downstream always ready.
    win_limit = 576;
    start_frame();
    run_frame(1'b0, seen_done, seen_err);
    full_frame_checks("frame_ready", seen_done, seen_err);

    // 2: downstream ready toggles every 4 cycles.
    start_frame();
    run_frame(1'b1, seen_done, seen_err);
    full_frame_checks("frame_toggle", seen_done, seen_err);

    // 3: abort at pix_cnt=300, then restart.
    start_frame();
    waited = 0;
    while (rd_cnt < 300 && waited < 2000) begin
      tick();
      waited++;
    end
    chk("abort_reached_300", (rd_cnt >= 300), 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_state", o_state, 3'd0);
    chk("abort_busy", o_busy, 0);
    chk("abort_rd_en", o_mem_rd_en, 0);
    chk("abort_done", o_done, 0);
    chk("abort_inflight_lb_valid", o_lb_valid, 1);
    tick();
    chk("abort_lb_valid_drained", o_lb_valid, 0);
    repeat (10) tick();
    chk("abort_no_done", done_cnt, 0);
    start_frame();
    run_frame(1'b0, seen_done, seen_err);
    full_frame_checks("restart", seen_done, seen_err);

    // 4: start held during FETCH; start with abort in FETCH.
    clear_monitor();
    i_start = 1'b1;
    repeat (20) tick();
    chk("held_start_state", o_state, 3'd2);
    chk("held_start_one_clear", clr_cnt, 1);
    i_abort = 1'b1;
    tick();
    chk("start_abort_state", o_state, 3'd0);
    chk("start_abort_no_clear", o_lb_clear, 0);
    i_abort = 1'b0;
    tick();
    chk("restart_in_idle_state", o_state, 3'd1);
    i_start = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_from_clear", o_state, 3'd0);
    repeat (5) tick();
    chk("start_abort_clear_total", clr_cnt, 2);
    chk("start_abort_no_done", done_cnt, 0);

    // 5: one window missing -> drain timeout.
    win_limit = 575;
    start_frame();
    run_frame(1'b0, seen_done, seen_err);
    chk("timeout_done", seen_done, 1);
    chk("timeout_err", seen_err, 1);
    chk("timeout_windows", mon_win, 575);
    chk("timeout_no_last", last_cnt, 0);
    chk("timeout_win_coords", win_err, 0);
    chk("timeout_idle_gap", done_cyc - last_win_cyc, 257);
    chk("timeout_idle_after", o_state, 3'd0);
    chk("timeout_err_cleared", o_err, 0);

    // 6: reset pulsed in DRAIN, then stray windows.
    start_frame();
    waited = 0;
    while (rd_cnt < 784 && waited < 2000) begin
      tick();
      waited++;
    end
    repeat (20) tick();
    chk("pre_reset_busy", o_busy, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_drain_reset");
    reset = 1'b0;
    force_win = 1'b1;
    repeat (3) tick();
    chk("stray_win_x", o_win_x, 0);
    chk("stray_win_y", o_win_y, 0);
    chk("stray_win_last", o_win_last, 0);
    chk("stray_state", o_state, 3'd0);
    chk("stray_busy", o_busy, 0);
    force_win = 1'b0;
    repeat (3) tick();
    chk("stray_no_done", o_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the 5x5 sliding-window front end of the CNN path.
- On a start command it streams one IX x IY frame from the image RAM into the line buffer in raster order. It then counts the windows the line buffer emits and tags each with its (x,y) output coordinate.
- It signals frame completion or a timeout error.
- Sits between the image RAM / top-level control and the line_buffer + conv engine.

Parameters:
- I_F_BW, 8, pixel width in bits
- IX, 28, frame width in pixels
- IY, 28, frame height in pixels
- KX, 5, window width
- KY, 5, window height
- TIMEOUT, 256, max cycles allowed in DRAIN without a window before error

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- i_start  input  1  start one frame (sampled in IDLE only)
- i_abort  input  1  cancel current frame
- i_ds_ready  input  1  downstream conv engine can accept windows
- o_mem_rd_en  output  1  image RAM read strobe
- o_mem_addr  output  $clog2(IX*IY)  image RAM read address
- i_mem_rdata  input  I_F_BW  image RAM data, valid 1 cycle after o_mem_rd_en
- o_lb_clear  output  1  one-cycle line-buffer re-init pulse
- o_lb_valid  output  1  pixel valid to line buffer
- o_lb_pixel  output  I_F_BW  pixel to line buffer
- i_lb_window_valid  input  1  line buffer window valid
- o_win_x  output  $clog2(IX)  x coordinate of current window
- o_win_y  output  $clog2(IY)  y coordinate of current window
- o_win_last  output  1  current window is the last of the frame
- o_busy  output  1  frame in progress
- o_done  output  1  one-cycle frame-complete pulse
- o_err  output  1  timeout flag, valid with o_done

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE. All counters 0. Every output 0.
- Derived constants: NWX=IX-KX+1 (24), NWY=IY-KY+1 (24), NWIN=NWX*NWY (576), NPIX=IX*IY (784).
- States: IDLE, CLEAR, FETCH, DRAIN, DONE.
- IDLE: o_busy=0. i_start=1 -> CLEAR. Clear pix_cnt, win_cnt, win_x, win_y, err.
- CLEAR: one cycle. o_lb_clear=1, o_busy=1. Next state is FETCH.
- FETCH:
  - Each cycle with i_ds_ready=1: o_mem_rd_en=1, o_mem_addr=pix_cnt, then pix_cnt++.
  - With i_ds_ready=0: no read, address held.
  - After the read with pix_cnt=NPIX-1 is issued -> DRAIN.
- Pixel path:
  - o_lb_valid is o_mem_rd_en delayed one register.
  - o_lb_pixel = i_mem_rdata (combinational passthrough).
  - Raster order is strict: addresses 0..NPIX-1, no gaps, no repeats.
- Window tracking (CLEAR, FETCH, DRAIN):
  - Each cycle with i_lb_window_valid=1: win_cnt++, and o_win_x/o_win_y advance.
  - x runs 0..NWX-1, then wraps to 0 and y increments.
  - o_win_x/o_win_y show the coordinate of the window currently valid.
  - o_win_last=1 when i_lb_window_valid=1 and win_cnt==NWIN-1.
- Windows after win_cnt reaches NWIN, or while in IDLE/DONE, are ignored (no count, no tag).
- DRAIN:
  - Idle counter increments each cycle with no window and clears on a window.
  - Last window counted -> DONE.
  - Idle counter reaches TIMEOUT -> err=1 -> DONE.
- Window count reaching NWIN during FETCH does not end the frame early: the FSM still goes to DRAIN, then to DONE on the next cycle.
- DONE: one cycle. o_done=1, o_err=err, o_busy=1. Next state is IDLE. o_err returns to 0 in IDLE.
- i_abort=1 in any non-IDLE state: next cycle IDLE, counters cleared, o_mem_rd_en=0, no o_done.
  - An o_lb_valid already in flight still issues once.
  - i_abort has priority over i_start.
- i_start outside IDLE is ignored.
- Backpressure contract: reads stop the cycle after i_ds_ready falls. The downstream must absorb windows already in the line-buffer pipeline (≤3 cycles).
- reset asserted in any state has priority over everything and applies reset values at the next edge.

Test Plan:
- Reset, start, i_ds_ready=1, behavioural line-buffer model (28x28, 5x5) -> addresses 0..783 on consecutive cycles. Exactly 576 windows tagged (0,0)..(23,23) in raster order. o_win_last with (23,23). One o_done with o_err=0.
- i_ds_ready toggles every 4 cycles -> no o_mem_rd_en while low. Address sequence still 0..783 with no duplicates. o_lb_valid count=784. Frame completes with o_err=0.
- Abort at pix_cnt=300 -> next cycle IDLE, o_busy=0, no o_done. Restart -> o_lb_clear pulse, then addresses restart at 0 and the full frame completes.
- i_start held during FETCH; i_start and i_abort asserted together in FETCH -> start ignored, abort wins. Exactly one CLEAR pulse per accepted start.
- Model emits only 575 windows -> 256 idle cycles in DRAIN, then o_done=1 with o_err=1, then IDLE.
- reset pulsed mid-DRAIN -> next edge all outputs 0 and state IDLE. Extra windows afterwards are ignored.
